dstack_op_unit: RTL and testbench
=================================

Name: dstack_op_unit

Overview:
- Upstream driver of the core0 data stack. Accepts stack/ALU ops over a valid/ready handshake and reads top/second/third/rot_val back from the stack.
- Drives the stack's movement, next_top, rotate and rot_addr inputs.
- Single-cycle ops complete at the accepting edge. An optional iterative multiply stalls the handshake.
- Flags stack overflow, stack underflow and illegal opcodes as a sticky fault.

Parameters:
- WIDTH, 32, data word width; must match the stack.
- ROT_W, 5, width of rot_addr / COPY and ROT index.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low (asserted when 0).
- op_valid  in  1  op offered.
- op_ready  out  1  op accepted when op_valid && op_ready.
- op_code  in  4  opcode.
- op_imm  in  WIDTH  immediate; PUSH value, or index in bits [ROT_W-1:0].
- top, second, third  in  WIDTH each  from stack.
- rot_val  in  WIDTH  stack element at rot_addr.
- overflow, underflow  in  1 each  from stack; combinational on movement.
- movement  out  2  00 none, 01 push, 10 pop, 11 pop twice.
- next_top  out  WIDTH  new top.
- rotate  out  1  rotate request.
- rot_addr  out  ROT_W  rotate/copy index.
- fault_clear  in  1  clears the sticky fault.
- fault  out  1  sticky fault.
- fault_code  out  2  01 overflow, 10 underflow, 11 illegal.

Behaviour:
- States: IDLE, MUL, FAULT.
- op_ready = 1 only in IDLE.
- Default outputs (not IDLE, or no handshake): movement=00, rotate=0, rot_addr=0, next_top=top, so the stack holds.
- Ops in IDLE are issued combinationally in the handshake cycle; the stack updates at the same edge (latency 0).
  - 0 NOP: default outputs.
  - 1 PUSH: movement=01, next_top=op_imm.
  - 2 DROP: movement=10, next_top=second.
  - 3 DUP: movement=01, next_top=top.
  - 4 SWAP: rotate=1, rot_addr=1, movement=00, next_top=rot_val.
  - 5 COPY n: rot_addr=n, movement=01, next_top=rot_val; n=0 behaves as DUP.
  - 6 ROT n: rotate=1, rot_addr=n, movement=00, next_top=rot_val; n=0 behaves as NOP.
  - 7 ADD: movement=10, next_top=second+top.
  - 8 SUB: movement=10, next_top=second-top.
  - 9 AND, A OR, B XOR: movement=10, next_top=second op top.
  - C SEL: movement=11, next_top = (top!=0) ? second : third.
  - D MUL: see Optional Feature.
  - E, F: illegal.
- Arithmetic is modulo 2^WIDTH; carries are discarded.
- Fault:
  - Sampled at the edge of any cycle where movement!=00.
  - overflow sets code 01; underflow sets code 10; an illegal opcode sets code 11 with default outputs.
  - The offending op still takes effect.
  - Go to FAULT; fault=1; the first code is held. Simultaneous overflow and underflow is impossible.
  - FAULT holds default outputs until fault_clear=1, which returns to IDLE at the next edge.
  - fault_clear in any other state is ignored.
- Async reset (reset=0):
  - State=IDLE; fault=0; fault_code=00; multiply registers cleared.
  - Outputs are forced to defaults and op_ready=0 while reset is asserted.
  - Reset during MUL abandons the op; the stack is left unchanged.

Optional Feature:
- Macro DSTACK_OP_MUL_EN.
- Defined:
  - MUL latches a=second, b=top at acceptance and enters MUL for WIDTH cycles of shift-add (one multiplier bit per cycle); op_ready=0 throughout.
  - Busy cycles 1..WIDTH-1 drive default outputs.
  - Busy cycle WIDTH drives movement=10, next_top=low WIDTH bits of a*b, and checks underflow.
  - Returns to IDLE after the busy cycle WIDTH edge, or to FAULT on underflow.
  - Accept-to-next-accept is WIDTH+1 cycles.
- Undefined: opcode D is illegal (code 11); no MUL state or multiplier registers exist.

Test Plan:
- PUSH 5, PUSH 7, ADD -> top=12, stack depth 1, fault=0; SUB after PUSH 9 -> top=3.
- PUSH 1, PUSH 2, PUSH 3, SWAP -> top=2, second=3; then ROT 2 -> top=1, second=2, third=3.
- PUSH 0xA, PUSH 0xB, PUSH 0 (selector), SEL -> top=0xA, depth 1; repeat with selector 1 -> top=0xB.
- From reset, DROP -> underflow, fault=1, fault_code=10, op_ready=0; fault_clear=1 -> op_ready=1 next cycle.
- Opcode 0xF -> fault_code=11, stack unchanged.
- With DSTACK_OP_MUL_EN: PUSH 6, PUSH 7, MUL -> op_ready low 32 cycles, then top=42, depth 1.
  - Assert reset at busy cycle 10 -> top still 7, state IDLE after release.

Source files
------------

// File: rtl/dstack_op_unit.sv
`default_nettype none
// ============================================================================
//  Module      : dstack_op_unit
//  Description : Upstream op driver for the core0 data stack. Accepts
//                stack/ALU ops on a valid/ready handshake, issues them to the
//                stack in the same cycle, and records overflow, underflow and
//                illegal opcodes as a sticky fault.
//                Optional feature macro: DSTACK_OP_MUL_EN enables an
//                iterative shift-add multiply (opcode D). Without it, D is
//                illegal.
//  Revision    : 1.0 - initial release
// ============================================================================
module dstack_op_unit #(
    parameter int WIDTH = 32,
    parameter int ROT_W = 5
) (
    input  logic             clk,
    input  logic             reset,        // asynchronous, active-low
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [3:0]       op_code,
    input  logic [WIDTH-1:0] op_imm,
    input  logic [WIDTH-1:0] top,
    input  logic [WIDTH-1:0] second,
    input  logic [WIDTH-1:0] third,
    input  logic [WIDTH-1:0] rot_val,
    input  logic             overflow,
    input  logic             underflow,
    output logic [1:0]       movement,
    output logic [WIDTH-1:0] next_top,
    output logic             rotate,
    output logic [ROT_W-1:0] rot_addr,
    input  logic             fault_clear,
    output logic             fault,
    output logic [1:0]       fault_code
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_FAULT = 2'd2;

    localparam logic [1:0] c_MV_NONE = 2'b00;
    localparam logic [1:0] c_MV_PUSH = 2'b01;
    localparam logic [1:0] c_MV_POP  = 2'b10;
    localparam logic [1:0] c_MV_POP2 = 2'b11;

    localparam logic [1:0] c_FC_OVER  = 2'b01;
    localparam logic [1:0] c_FC_UNDER = 2'b10;
    localparam logic [1:0] c_FC_ILL   = 2'b11;

    localparam logic [3:0] c_OP_NOP  = 4'h0;
    localparam logic [3:0] c_OP_PUSH = 4'h1;
    localparam logic [3:0] c_OP_DROP = 4'h2;
    localparam logic [3:0] c_OP_DUP  = 4'h3;
    localparam logic [3:0] c_OP_SWAP = 4'h4;
    localparam logic [3:0] c_OP_COPY = 4'h5;
    localparam logic [3:0] c_OP_ROT  = 4'h6;
    localparam logic [3:0] c_OP_ADD  = 4'h7;
    localparam logic [3:0] c_OP_SUB  = 4'h8;
    localparam logic [3:0] c_OP_AND  = 4'h9;
    localparam logic [3:0] c_OP_OR   = 4'hA;
    localparam logic [3:0] c_OP_XOR  = 4'hB;
    localparam logic [3:0] c_OP_SEL  = 4'hC;

    logic [1:0]       r_state;
    logic             r_fault;
    logic [1:0]       r_fault_code;

    logic             w_accept;
    logic [ROT_W-1:0] w_idx;
    logic [1:0]       w_movement;
    logic [WIDTH-1:0] w_next_top;
    logic             w_rotate;
    logic [ROT_W-1:0] w_rot_addr;
    logic             w_illegal;
    logic             w_fault_evt;
    logic [1:0]       w_fault_code;

`ifdef DSTACK_OP_MUL_EN
    localparam logic [1:0] c_ST_MUL  = 2'd1;
    localparam logic [3:0] c_OP_MUL  = 4'hD;
    localparam int         c_CNT_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0]   r_mul_a;     // multiplicand, shifted left each cycle
    logic [WIDTH-1:0]   r_mul_b;     // multiplier, shifted right each cycle
    logic [WIDTH-1:0]   r_mul_acc;
    logic [c_CNT_W-1:0] r_mul_cnt;
    logic [WIDTH-1:0]   w_mul_sum;
    logic               w_mul_last;
    logic               w_mul_start;

    // The final busy cycle folds in the last multiplier bit combinationally,
    // so the product is issued to the stack at that cycle's edge.
    assign w_mul_sum  = r_mul_acc + (r_mul_b[0] ? r_mul_a : '0);
    assign w_mul_last = (r_mul_cnt == c_CNT_LAST);
`endif

    // reset is active-low: a handshake can only happen while it is released.
    assign w_accept = reset && op_valid && (r_state == c_ST_IDLE);
    assign w_idx    = op_imm[ROT_W-1:0];

    // Decode the accepted op (or the multiply result) into stack controls.
    always_comb begin
        w_movement = c_MV_NONE;
        w_next_top = top;
        w_rotate   = 1'b0;
        w_rot_addr = '0;
        w_illegal  = 1'b0;
`ifdef DSTACK_OP_MUL_EN
        w_mul_start = 1'b0;
`endif
        if (w_accept) begin
            case (op_code)
                c_OP_NOP: ;
                c_OP_PUSH: begin
                    w_movement = c_MV_PUSH;
                    w_next_top = op_imm;
                end
                c_OP_DROP: begin
                    w_movement = c_MV_POP;
                    w_next_top = second;
                end
                c_OP_DUP: begin
                    w_movement = c_MV_PUSH;
                    w_next_top = top;
                end
                c_OP_SWAP: begin
                    w_rotate   = 1'b1;
                    w_rot_addr = ROT_W'(1);
                    w_next_top = rot_val;
                end
                c_OP_COPY: begin
                    // Index 0 is a plain DUP; avoid depending on rot_val there.
                    w_movement = c_MV_PUSH;
                    if (w_idx != '0) begin
                        w_rot_addr = w_idx;
                        w_next_top = rot_val;
                    end
                end
                c_OP_ROT: begin
                    // Index 0 leaves the stack untouched (NOP).
                    if (w_idx != '0) begin
                        w_rotate   = 1'b1;
                        w_rot_addr = w_idx;
                        w_next_top = rot_val;
                    end
                end
                c_OP_ADD: begin
                    w_movement = c_MV_POP;
                    w_next_top = second + top;
                end
                c_OP_SUB: begin
                    w_movement = c_MV_POP;
                    w_next_top = second - top;
                end
                c_OP_AND: begin
                    w_movement = c_MV_POP;
                    w_next_top = second & top;
                end
                c_OP_OR: begin
                    w_movement = c_MV_POP;
                    w_next_top = second | top;
                end
                c_OP_XOR: begin
                    w_movement = c_MV_POP;
                    w_next_top = second ^ top;
                end
                c_OP_SEL: begin
                    w_movement = c_MV_POP2;
                    w_next_top = (top != '0) ? second : third;
                end
`ifdef DSTACK_OP_MUL_EN
                c_OP_MUL: w_mul_start = 1'b1;
`endif
                default: w_illegal = 1'b1;
            endcase
        end
`ifdef DSTACK_OP_MUL_EN
        else if (reset && (r_state == c_ST_MUL) && w_mul_last) begin
            w_movement = c_MV_POP;
            w_next_top = w_mul_sum;
        end
`endif
    end

    // Stack status only counts in cycles where the stack actually moves.
    assign w_fault_evt  = w_illegal ||
                          ((w_movement != c_MV_NONE) && (overflow || underflow));
    assign w_fault_code = w_illegal ? c_FC_ILL :
                          (overflow ? c_FC_OVER : c_FC_UNDER);

    assign movement   = w_movement;
    assign next_top   = w_next_top;
    assign rotate     = w_rotate;
    assign rot_addr   = w_rot_addr;
    assign op_ready   = reset && (r_state == c_ST_IDLE);
    assign fault      = r_fault;
    assign fault_code = r_fault_code;

    // Control FSM: a fault event wins over any other transition and latches
    // the first code; only fault_clear leaves FAULT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= c_ST_IDLE;
            r_fault      <= 1'b0;
            r_fault_code <= 2'b00;
        end else if (w_fault_evt && (r_state != c_ST_FAULT)) begin
            r_state      <= c_ST_FAULT;
            r_fault      <= 1'b1;
            r_fault_code <= w_fault_code;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
`ifdef DSTACK_OP_MUL_EN
                    if (w_mul_start) begin
                        r_state <= c_ST_MUL;
                    end
`endif
                end
`ifdef DSTACK_OP_MUL_EN
                c_ST_MUL: begin
                    if (w_mul_last) begin
                        r_state <= c_ST_IDLE;
                    end
                end
`endif
                c_ST_FAULT: begin
                    if (fault_clear) begin
                        r_state      <= c_ST_IDLE;
                        r_fault      <= 1'b0;
                        r_fault_code <= 2'b00;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

`ifdef DSTACK_OP_MUL_EN
    // Shift-add datapath: operands latched at acceptance, one bit per cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mul_a   <= '0;
            r_mul_b   <= '0;
            r_mul_acc <= '0;
            r_mul_cnt <= '0;
        end else if (w_mul_start) begin
            r_mul_a   <= second;
            r_mul_b   <= top;
            r_mul_acc <= '0;
            r_mul_cnt <= '0;
        end else if (r_state == c_ST_MUL) begin
            r_mul_a   <= r_mul_a << 1;
            r_mul_b   <= r_mul_b >> 1;
            r_mul_acc <= w_mul_sum;
            r_mul_cnt <= r_mul_cnt + 1'b1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_dstack_op_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dstack_op_unit
//  Description : Self-checking bench for dstack_op_unit. Contains a simple
//                stack (driven by the DUT) and a queue-based op model.
//                Multiply checks are built when DSTACK_OP_MUL_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dstack_op_unit;

    localparam int W     = 32;
    localparam int RW    = 5;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          op_valid;
    logic          op_ready;
    logic [3:0]    op_code;
    logic [W-1:0]  op_imm;
    logic [W-1:0]  top, second, third, rot_val;
    logic          overflow, underflow;
    logic [1:0]    movement;
    logic [W-1:0]  next_top;
    logic          rotate;
    logic [RW-1:0] rot_addr;
    logic          fault_clear;
    logic          fault;
    logic [1:0]    fault_code;

    int errors = 0;
    int checks = 0;

    // Stack that the DUT drives.
    logic [W-1:0] st [0:31];
    int           sdepth;
    logic         stk_clr;

    // Reference model: element 0 is the top of stack.
    logic [W-1:0] ref_q [$];

    dstack_op_unit #(.WIDTH(W), .ROT_W(RW)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
        .op_code(op_code), .op_imm(op_imm), .top(top), .second(second),
        .third(third), .rot_val(rot_val), .overflow(overflow),
        .underflow(underflow), .movement(movement), .next_top(next_top),
        .rotate(rotate), .rot_addr(rot_addr), .fault_clear(fault_clear),
        .fault(fault), .fault_code(fault_code)
    );

    always #5 clk = ~clk;

    assign top       = st[0];
    assign second    = st[1];
    assign third     = st[2];
    assign rot_val   = st[rot_addr];
    assign overflow  = (movement == 2'b01) && (sdepth == DEPTH);
    assign underflow = ((movement == 2'b10) && (sdepth == 0)) ||
                       ((movement == 2'b11) && (sdepth < 2));

    // Stack behaviour: rotate moves element n to the top, movement shifts.
    always @(posedge clk) begin
        if (stk_clr) begin
            sdepth <= 0;
            for (int i = 0; i < 32; i++) st[i] <= '0;
        end else if (rotate) begin
            for (int i = 1; i < 32; i++) if (i <= int'(rot_addr)) st[i] <= st[i-1];
            st[0] <= next_top;
        end else begin
            case (movement)
                2'b01: begin
                    for (int i = 1; i < 32; i++) st[i] <= st[i-1];
                    sdepth <= (sdepth == DEPTH) ? DEPTH : sdepth + 1;
                end
                2'b10: begin
                    for (int i = 1; i < 31; i++) st[i] <= st[i+1];
                    sdepth <= (sdepth == 0) ? 0 : sdepth - 1;
                end
                2'b11: begin
                    for (int i = 1; i < 30; i++) st[i] <= st[i+2];
                    sdepth <= (sdepth < 2) ? 0 : sdepth - 2;
                end
                default: ;
            endcase
            st[0] <= next_top;
        end
    end

    task automatic ref_apply(input logic [3:0] code, input logic [W-1:0] imm);
        logic [W-1:0] a, b, c;
        int n;
        n = int'(imm[RW-1:0]);
        case (code)
            4'h1: ref_q.push_front(imm);
            4'h2: void'(ref_q.pop_front());
            4'h3: ref_q.push_front(ref_q[0]);
            4'h4: begin a = ref_q[0]; ref_q[0] = ref_q[1]; ref_q[1] = a; end
            4'h5: ref_q.push_front(ref_q[n]);
            4'h6: begin a = ref_q[n]; ref_q.delete(n); ref_q.push_front(a); end
            4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hD: begin
                b = ref_q.pop_front();
                a = ref_q.pop_front();
                case (code)
                    4'h7: c = a + b;
                    4'h8: c = a - b;
                    4'h9: c = a & b;
                    4'hA: c = a | b;
                    4'hB: c = a ^ b;
                    default: c = a * b;
                endcase
                ref_q.push_front(c);
            end
            4'hC: begin
                a = ref_q.pop_front();
                b = ref_q.pop_front();
                c = ref_q.pop_front();
                ref_q.push_front((a != 0) ? b : c);
            end
            default: ;
        endcase
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic do_op(input logic [3:0] code, input logic [W-1:0] imm);
        int waited = 0;
        op_code  = code;
        op_imm   = imm;
        op_valid = 1'b1;
        while (!op_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!op_ready) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout: op %h not accepted after %0d cycles", code, waited);
            op_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        op_valid = 1'b0;
    endtask

    task automatic stack_clear();
        stk_clr = 1'b1;
        @(negedge clk);
        stk_clr = 1'b0;
        ref_q.delete();
    endtask

    task automatic pulse_clear();
        fault_clear = 1'b1;
        @(negedge clk);
        fault_clear = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; stk_clr = 1'b1; fault_clear = 1'b0;
        op_valid = 1'b1; op_code = 4'h1; op_imm = 32'hDEAD_BEEF;
        repeat (2) @(negedge clk);
        stk_clr = 1'b0;
        @(negedge clk);
        checks++; if (op_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", op_ready); end
        checks++; if (movement !== 2'b00) begin errors++; $display("FAIL rst_movement: got %b want 00", movement); end
        checks++; if (rotate !== 1'b0) begin errors++; $display("FAIL rst_rotate: got %b want 0", rotate); end
        checks++; if (next_top !== '0) begin errors++; $display("FAIL rst_next_top: got %h want 0", next_top); end
        checks++; if (fault !== 1'b0 || fault_code !== 2'b00) begin errors++; $display("FAIL rst_fault: got %b/%b want 0/00", fault, fault_code); end
        op_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b want 1", op_ready); end
        checks++; if (sdepth !== 0) begin errors++; $display("FAIL rst_depth: got %0d want 0", sdepth); end
    endtask

    task automatic test_arith();
        stack_clear();
        do_op(4'h1, 5); do_op(4'h1, 7); do_op(4'h7, 0);
        checks++; if (top !== 32'd12) begin errors++; $display("FAIL add_top: got %0d want 12", top); end
        checks++; if (sdepth !== 1) begin errors++; $display("FAIL add_depth: got %0d want 1", sdepth); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL add_fault: got %b want 0", fault); end
        do_op(4'h1, 9); do_op(4'h8, 0);
        checks++; if (top !== 32'd3) begin errors++; $display("FAIL sub_top: got %0d want 3", top); end
        do_op(4'h1, 0); do_op(4'h1, 1); do_op(4'h8, 0);
        checks++; if (top !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sub_wrap: got %h want ffffffff", top); end
        checks++; if (sdepth !== 2) begin errors++; $display("FAIL sub_wrap_depth: got %0d want 2", sdepth); end
    endtask

    task automatic test_rotate();
        stack_clear();
        do_op(4'h1, 1); do_op(4'h1, 2); do_op(4'h1, 3); do_op(4'h4, 0);
        checks++; if (top !== 32'd2 || second !== 32'd3) begin errors++; $display("FAIL swap: got %0d,%0d want 2,3", top, second); end
        do_op(4'h6, 2);
        checks++; if (top !== 32'd1 || second !== 32'd2 || third !== 32'd3) begin
            errors++; $display("FAIL rot2: got %0d,%0d,%0d want 1,2,3", top, second, third); end
        do_op(4'h5, 32'hFFFF_FF02);
        checks++; if (top !== 32'd3 || sdepth !== 4) begin errors++; $display("FAIL copy2: got %0d depth %0d want 3 depth 4", top, sdepth); end
        do_op(4'h6, 0);
        checks++; if (top !== 32'd3 || second !== 32'd1 || sdepth !== 4) begin
            errors++; $display("FAIL rot0: got %0d,%0d depth %0d want 3,1 depth 4", top, second, sdepth); end
    endtask

    task automatic test_sel();
        stack_clear();
        do_op(4'h1, 32'hA); do_op(4'h1, 32'hB); do_op(4'h1, 0); do_op(4'hC, 0);
        checks++; if (top !== 32'hA || sdepth !== 1) begin errors++; $display("FAIL sel0: got %h depth %0d want a depth 1", top, sdepth); end
        stack_clear();
        do_op(4'h1, 32'hA); do_op(4'h1, 32'hB); do_op(4'h1, 1); do_op(4'hC, 0);
        checks++; if (top !== 32'hB || sdepth !== 1) begin errors++; $display("FAIL sel1: got %h depth %0d want b depth 1", top, sdepth); end
    endtask

    task automatic test_underflow();
        reset = 1'b0; stk_clr = 1'b1;
        @(negedge clk);
        reset = 1'b1; stk_clr = 1'b0;
        @(negedge clk);
        do_op(4'h2, 0);
        checks++; if (fault !== 1'b1 || fault_code !== 2'b10) begin errors++; $display("FAIL underflow_code: got %b/%b want 1/10", fault, fault_code); end
        checks++; if (op_ready !== 1'b0) begin errors++; $display("FAIL underflow_ready: got %b want 0", op_ready); end
        op_valid = 1'b1; op_code = 4'h1; op_imm = 32'h77;
        repeat (2) @(negedge clk);
        op_valid = 1'b0;
        checks++; if (sdepth !== 0 || fault_code !== 2'b10) begin errors++; $display("FAIL fault_hold: depth %0d code %b want 0/10", sdepth, fault_code); end
        pulse_clear();
        checks++; if (op_ready !== 1'b1 || fault !== 1'b0) begin errors++; $display("FAIL fault_clear: ready %b fault %b want 1/0", op_ready, fault); end
    endtask

    task automatic test_illegal();
        logic [3:0] codes [$];
        codes = '{4'hF, 4'hE};
`ifndef DSTACK_OP_MUL_EN
        codes.push_back(4'hD);
`endif
        stack_clear();
        do_op(4'h1, 32'h55);
        foreach (codes[k]) begin
            do_op(codes[k], 32'h1234);
            checks++; if (fault !== 1'b1 || fault_code !== 2'b11) begin
                errors++; $display("FAIL illegal_%h: got %b/%b want 1/11", codes[k], fault, fault_code); end
            checks++; if (top !== 32'h55 || sdepth !== 1) begin
                errors++; $display("FAIL illegal_%h_stack: got %h depth %0d want 55 depth 1", codes[k], top, sdepth); end
            pulse_clear();
        end
    endtask

    task automatic test_overflow();
        stack_clear();
        for (int i = 0; i < DEPTH; i++) do_op(4'h1, 32'(i + 1));
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL full_no_fault: got %b want 0", fault); end
        do_op(4'h1, 32'h99);
        checks++; if (fault !== 1'b1 || fault_code !== 2'b01) begin errors++; $display("FAIL overflow_code: got %b/%b want 1/01", fault, fault_code); end
        checks++; if (top !== 32'h99) begin errors++; $display("FAIL overflow_effect: got %h want 99", top); end
        pulse_clear();
        stack_clear();
    endtask

    task automatic test_back_to_back_random();
        logic [3:0]   code;
        logic [W-1:0] imm;
        int d, r, n, waited;
        stack_clear();
        for (int it = 0; it < 200; it++) begin
            d   = ref_q.size();
            r   = $urandom_range(0, 13);
            imm = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : 32'($urandom());
            n   = (d > 0) ? $urandom_range(0, d - 1) : 0;
            case (r)
                0:  code = 4'h0;
                1:  code = (d < DEPTH) ? 4'h1 : 4'h2;
                2:  code = (d >= 1) ? 4'h2 : 4'h1;
                3:  code = (d >= 1 && d < DEPTH) ? 4'h3 : ((d == 0) ? 4'h1 : 4'h2);
                4:  code = (d >= 2) ? 4'h4 : 4'h1;
                5:  code = (d >= 1 && d < DEPTH) ? 4'h5 : ((d == 0) ? 4'h1 : 4'h2);
                6:  code = (d >= 1) ? 4'h6 : 4'h1;
                12: code = (d >= 3) ? 4'hC : 4'h1;
`ifdef DSTACK_OP_MUL_EN
                13: code = (d >= 2) ? 4'hD : 4'h1;
`else
                13: code = (d >= 2) ? 4'h7 : 4'h1;
`endif
                default: code = (d >= 2) ? 4'(r) : 4'h1;
            endcase
            if (code == 4'h5 || code == 4'h6) imm = (imm & ~32'h1F) | 32'(n);
            do_op(code, imm);
            ref_apply(code, imm);
            waited = 0;
            while (!op_ready && waited < 100) begin @(negedge clk); waited++; end
            checks++; if (sdepth !== ref_q.size()) begin
                errors++; $display("FAIL rand_depth it%0d op%h: got %0d want %0d", it, code, sdepth, ref_q.size()); end
            for (int i = 0; i < ref_q.size(); i++) begin
                checks++; if (st[i] !== ref_q[i]) begin
                    errors++; $display("FAIL rand_elem it%0d op%h [%0d]: got %h want %h", it, code, i, st[i], ref_q[i]); end
            end
            checks++; if (fault !== 1'b0 || op_ready !== 1'b1) begin
                errors++; $display("FAIL rand_status it%0d op%h: fault %b ready %b want 0/1", it, code, fault, op_ready); end
        end
    endtask

`ifdef DSTACK_OP_MUL_EN
    task automatic test_mul();
        int busy;
        logic [W-1:0] a, b;
        stack_clear();
        do_op(4'h1, 6); do_op(4'h1, 7); do_op(4'hD, 0);
        busy = 0;
        while (!op_ready && busy < 100) begin busy++; @(negedge clk); end
        checks++; if (busy !== W) begin errors++; $display("FAIL mul_busy: got %0d want %0d", busy, W); end
        checks++; if (top !== 32'd42 || sdepth !== 1) begin errors++; $display("FAIL mul_result: got %0d depth %0d want 42 depth 1", top, sdepth); end
        for (int k = 0; k < 4; k++) begin
            a = $urandom(); b = $urandom();
            stack_clear();
            do_op(4'h1, a); do_op(4'h1, b); do_op(4'hD, 0);
            busy = 0;
            while (!op_ready && busy < 100) begin busy++; @(negedge clk); end
            checks++; if (top !== W'(a * b)) begin errors++; $display("FAIL mul_rand%0d: got %h want %h", k, top, W'(a * b)); end
        end
        stack_clear();
        do_op(4'h1, 6); do_op(4'h1, 7); do_op(4'hD, 0);
        repeat (9) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++; if (movement !== 2'b00 || op_ready !== 1'b0) begin
            errors++; $display("FAIL mul_rst_outputs: mv %b ready %b want 00/0", movement, op_ready); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (top !== 32'd7 || sdepth !== 2) begin errors++; $display("FAIL mul_rst_stack: got %0d depth %0d want 7 depth 2", top, sdepth); end
        checks++; if (op_ready !== 1'b1 || fault !== 1'b0) begin errors++; $display("FAIL mul_rst_idle: ready %b fault %b want 1/0", op_ready, fault); end
        repeat (W + 2) @(negedge clk);
        checks++; if (top !== 32'd7 || sdepth !== 2) begin errors++; $display("FAIL mul_rst_quiet: got %0d depth %0d want 7 depth 2", top, sdepth); end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_arith();
        test_rotate();
        test_sel();
        test_underflow();
        test_illegal();
        test_overflow();
        test_back_to_back_random();
`ifdef DSTACK_OP_MUL_EN
        test_mul();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
